// File: rtl/readout_rx_state_decision_controller_google_if.sv
// -----------------------------------------------------------------------------
// readout_rx_state_decision_controller_google_if
// Request/result bundle between the readout scheduler (master) and the state
// decision sequencer (slave).
//   meas_req_*   : measurement request handshake + integration length
//   coeff_req_*  : classifier coefficient write handshake + address/data
//   result_*     : one-cycle result strobe, measured bit, forced-result flag
//   busy         : sequencer is not idle
// -----------------------------------------------------------------------------
interface readout_rx_state_decision_controller_google_if #(
  parameter int STATE_DECISION_DATA_WIDTH = 8,
  parameter int STATE_DECISION_ADDR_WIDTH = 1,
  parameter int BIN_COUNT_WIDTH           = 10
);
  logic                                 meas_req_valid;
  logic                                 meas_req_ready;
  logic [BIN_COUNT_WIDTH-1:0]           meas_req_bin_count;
  logic                                 coeff_req_valid;
  logic                                 coeff_req_ready;
  logic [STATE_DECISION_ADDR_WIDTH-1:0] coeff_req_addr;
  logic [STATE_DECISION_DATA_WIDTH-1:0] coeff_req_data;
  logic                                 result_valid;
  logic                                 result_out;
  logic                                 result_timeout;
  logic                                 busy;

  modport master (
    output meas_req_valid, meas_req_bin_count,
    output coeff_req_valid, coeff_req_addr, coeff_req_data,
    input  meas_req_ready, coeff_req_ready,
    input  result_valid, result_out, result_timeout, busy
  );

  modport slave (
    input  meas_req_valid, meas_req_bin_count,
    input  coeff_req_valid, coeff_req_addr, coeff_req_data,
    output meas_req_ready, coeff_req_ready,
    output result_valid, result_out, result_timeout, busy
  );
endinterface

// File: rtl/readout_rx_state_decision_controller_google.sv
// -----------------------------------------------------------------------------
// readout_rx_state_decision_controller_google
// Sequencer for one readout state decision unit: writes classifier
// coefficients while idle, opens/closes the integration window with
// start_count/finish_count after a requested number of valid IQ samples, then
// collects the one-bit result or forces one after a watchdog expires.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   req_if (slave)               : request/result bundle toward the scheduler
//   sample_valid_in              : copy of the decision unit's valid_in
//   start_count, finish_count    : one-cycle window pulses
//   state_decision_coeff_wr_*    : coefficient write strobe/address/data
//   valid_meas_result_in,
//   meas_result_in               : result strobe/bit from the decision unit
// RESULT_TIMEOUT must be smaller than 2**TIMEOUT_WIDTH.
// -----------------------------------------------------------------------------
module readout_rx_state_decision_controller_google #(
  parameter int STATE_DECISION_DATA_WIDTH = 8,
  parameter int STATE_DECISION_ADDR_WIDTH = 1,
  parameter int BIN_COUNT_WIDTH           = 10,
  parameter int RESULT_TIMEOUT            = 8,
  parameter int TIMEOUT_WIDTH             = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  readout_rx_state_decision_controller_google_if.slave req_if,
  input  logic                                 sample_valid_in,
  output logic                                 start_count,
  output logic                                 finish_count,
  output logic                                 state_decision_coeff_wr_en,
  output logic [STATE_DECISION_ADDR_WIDTH-1:0] state_decision_coeff_wr_addr,
  output logic [STATE_DECISION_DATA_WIDTH-1:0] state_decision_coeff_wr_data,
  input  logic                                 valid_meas_result_in,
  input  logic                                 meas_result_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_INTEGRATE,
    S_FINISH,
    S_WAIT_RESULT
  } state_e;

  localparam logic [BIN_COUNT_WIDTH-1:0] BIN_ONE      = BIN_COUNT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0]   WDOG_ONE     = TIMEOUT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_LAST = TIMEOUT_WIDTH'(RESULT_TIMEOUT - 1);

  state_e                               state_q, state_d;
  logic [BIN_COUNT_WIDTH-1:0]           target_q, target_d;
  logic [BIN_COUNT_WIDTH-1:0]           sample_cnt_q, sample_cnt_d;
  logic [TIMEOUT_WIDTH-1:0]             wdog_q, wdog_d;
  logic                                 start_q, start_d;
  logic                                 finish_q, finish_d;
  logic                                 wr_en_q, wr_en_d;
  logic [STATE_DECISION_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [STATE_DECISION_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                                 result_valid_q, result_valid_d;
  logic                                 result_out_q, result_out_d;
  logic                                 result_timeout_q, result_timeout_d;
  logic                                 busy_q, busy_d;
  logic                                 coeff_ready;
  logic                                 meas_ready;

  // NOTE: every signal assigned in this block gets a default first so no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    sample_cnt_d     = sample_cnt_q;
    wdog_d           = wdog_q;
    start_d          = 1'b0;
    finish_d         = 1'b0;
    wr_en_d          = 1'b0;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    result_valid_d   = 1'b0;
    result_out_d     = result_out_q;
    result_timeout_d = result_timeout_q;
    coeff_ready      = 1'b0;
    meas_ready       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Coefficient writes take priority over a simultaneous measurement.
        coeff_ready = req_if.coeff_req_valid;
        meas_ready  = req_if.meas_req_valid & ~req_if.coeff_req_valid;
        if (coeff_ready) begin
          wr_en_d   = 1'b1;
          wr_addr_d = req_if.coeff_req_addr;
          wr_data_d = req_if.coeff_req_data;
        end else if (meas_ready) begin
          // A zero-length request still integrates a single sample.
          target_d     = (req_if.meas_req_bin_count == '0) ? BIN_ONE
                                                          : req_if.meas_req_bin_count;
          sample_cnt_d = '0;
          start_d      = 1'b1;
          state_d      = S_START;
        end
      end

      // Accumulator is being cleared this cycle, so samples here are ignored.
      S_START: state_d = S_INTEGRATE;

      S_INTEGRATE: begin
        if (sample_valid_in) begin
          if (sample_cnt_q == target_q - BIN_ONE) begin
            finish_d = 1'b1;
            state_d  = S_FINISH;
          end else begin
            sample_cnt_d = sample_cnt_q + BIN_ONE;
          end
        end
      end

      S_FINISH: begin
        wdog_d  = '0;
        state_d = S_WAIT_RESULT;
      end

      S_WAIT_RESULT: begin
        // A strobe in the final watchdog cycle still beats the timeout.
        if (valid_meas_result_in) begin
          result_valid_d   = 1'b1;
          result_out_d     = meas_result_in;
          result_timeout_d = 1'b0;
          state_d          = S_IDLE;
        end else if (wdog_q == TIMEOUT_LAST) begin
          result_valid_d   = 1'b1;
          result_out_d     = 1'b0;
          result_timeout_d = 1'b1;
          state_d          = S_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      target_q         <= '0;
      sample_cnt_q     <= '0;
      wdog_q           <= '0;
      start_q          <= 1'b0;
      finish_q         <= 1'b0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      result_valid_q   <= 1'b0;
      result_out_q     <= 1'b0;
      result_timeout_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      sample_cnt_q     <= sample_cnt_d;
      wdog_q           <= wdog_d;
      start_q          <= start_d;
      finish_q         <= finish_d;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      result_valid_q   <= result_valid_d;
      result_out_q     <= result_out_d;
      result_timeout_q <= result_timeout_d;
      busy_q           <= busy_d;
    end
  end

  assign req_if.coeff_req_ready       = coeff_ready;
  assign req_if.meas_req_ready        = meas_ready;
  assign req_if.result_valid          = result_valid_q;
  assign req_if.result_out            = result_out_q;
  assign req_if.result_timeout        = result_timeout_q;
  assign req_if.busy                  = busy_q;
  assign start_count                  = start_q;
  assign finish_count                 = finish_q;
  assign state_decision_coeff_wr_en   = wr_en_q;
  assign state_decision_coeff_wr_addr = wr_addr_q;
  assign state_decision_coeff_wr_data = wr_data_q;

endmodule

// File: tb/tb_readout_rx_state_decision_controller_google.sv
// -----------------------------------------------------------------------------
// tb_readout_rx_state_decision_controller_google
// Self-checking bench: each measurement is planned as a transaction (length,
// sample/gap pattern, result delay) and the expected pulse timeline is derived
// from that plan; randomized traffic mixes coefficient writes, idles, stray
// result strobes, held requests and a reset in the middle of a window.
// -----------------------------------------------------------------------------
module tb_readout_rx_state_decision_controller_google;

  localparam int DW      = 8;
  localparam int AW      = 1;
  localparam int BW      = 10;
  localparam int TIMEOUT = 8;

  logic          clk;
  logic          rst;
  logic          sample_valid_in;
  logic          valid_meas_result_in;
  logic          meas_result_in;
  logic          start_count;
  logic          finish_count;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  readout_rx_state_decision_controller_google_if #(
    .STATE_DECISION_DATA_WIDTH(DW),
    .STATE_DECISION_ADDR_WIDTH(AW),
    .BIN_COUNT_WIDTH(BW)
  ) bus ();

  readout_rx_state_decision_controller_google #(
    .STATE_DECISION_DATA_WIDTH(DW),
    .STATE_DECISION_ADDR_WIDTH(AW),
    .BIN_COUNT_WIDTH(BW),
    .RESULT_TIMEOUT(TIMEOUT),
    .TIMEOUT_WIDTH(4)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .req_if                       (bus.slave),
    .sample_valid_in              (sample_valid_in),
    .start_count                  (start_count),
    .finish_count                 (finish_count),
    .state_decision_coeff_wr_en   (wr_en),
    .state_decision_coeff_wr_addr (wr_addr),
    .state_decision_coeff_wr_data (wr_data),
    .valid_meas_result_in         (valid_meas_result_in),
    .meas_result_in               (meas_result_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Held result seen by the requester since the last result_valid.
  bit exp_out = 1'b0;
  bit exp_to  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic observe(input string tag, input bit e_start, input bit e_finish,
                         input bit e_rv, input bit e_busy, input bit e_wr);
    check({tag, "/start_count"},    start_count,        e_start);
    check({tag, "/finish_count"},   finish_count,       e_finish);
    check({tag, "/result_valid"},   bus.result_valid,   e_rv);
    check({tag, "/result_out"},     bus.result_out,     exp_out);
    check({tag, "/result_timeout"}, bus.result_timeout, exp_to);
    check({tag, "/busy"},           bus.busy,           e_busy);
    check({tag, "/wr_en"},          wr_en,              e_wr);
  endtask

  task automatic busy_readies(input string tag);
    #1;
    check({tag, "/meas_ready_busy"},  bus.meas_req_ready,  1'b0);
    check({tag, "/coeff_ready_busy"}, bus.coeff_req_ready, 1'b0);
  endtask

  // Idle cycles with random samples and stray result strobes: nothing may fire.
  task automatic drive_idle(input int n);
    bus.meas_req_valid  = 1'b0;
    bus.coeff_req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      sample_valid_in      = 1'($urandom_range(0, 1));
      valid_meas_result_in = 1'($urandom_range(0, 1));
      meas_result_in       = 1'($urandom_range(0, 1));
      step();
      observe("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    valid_meas_result_in = 1'b0;
  endtask

  // Back-to-back coefficient writes; with_meas keeps a competing measurement
  // request raised, which must lose every cycle and stay pending afterwards.
  task automatic coeff_burst(input int n, input bit directed, input bit with_meas);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      a = directed ? AW'(i) : AW'($urandom);
      d = directed ? ((i == 0) ? 8'h12 : 8'hF3) : DW'($urandom);
      bus.coeff_req_valid    = 1'b1;
      bus.coeff_req_addr     = a;
      bus.coeff_req_data     = d;
      bus.meas_req_valid     = with_meas ? 1'b1 : 1'($urandom_range(0, 1));
      bus.meas_req_bin_count = BW'($urandom_range(0, 12));
      valid_meas_result_in   = 1'($urandom_range(0, 1));
      #1;
      check("coeff_ready", bus.coeff_req_ready, 1'b1);
      check("meas_ready_loses", bus.meas_req_ready, 1'b0);
      step();
      observe("coeff", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("wr_addr", wr_addr, a);
      check("wr_data", wr_data, d);
    end
    bus.coeff_req_valid  = 1'b0;
    bus.meas_req_valid   = with_meas;
    valid_meas_result_in = 1'b0;
  endtask

  // One measurement transaction. The first gap_at-th INTEGRATE cycle is forced
  // idle (-1 = none), others idle with gap_pct probability. strobe_at is the
  // WAIT_RESULT cycle (1-based) that carries the result strobe; anything past
  // TIMEOUT means no strobe and a forced result after TIMEOUT cycles.
  task automatic run_meas(input int bin, input int strobe_at, input bit res_bit,
                          input bit hold, input int gap_at, input int gap_pct);
    int target;
    int got;
    int cyc;
    bit smp;
    bit strobe;
    target = (bin == 0) ? 1 : bin;
    got    = 0;

    bus.meas_req_valid     = 1'b1;
    bus.meas_req_bin_count = BW'(bin);
    bus.coeff_req_valid    = 1'b0;
    sample_valid_in        = 1'($urandom_range(0, 1));
    valid_meas_result_in   = 1'($urandom_range(0, 1));
    #1;
    check("meas_ready_idle", bus.meas_req_ready, 1'b1);
    step();
    observe("accept", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    if (!hold) bus.meas_req_valid = 1'b0;

    // START cycle: a sample here must not count toward the window.
    sample_valid_in      = 1'($urandom_range(0, 1));
    valid_meas_result_in = 1'($urandom_range(0, 1));
    meas_result_in       = 1'($urandom_range(0, 1));
    busy_readies("start");
    step();
    observe("start_cycle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    cyc = 0;
    while (got < target) begin
      if (cyc == gap_at)   smp = 1'b0;
      else if (cyc > 200)  smp = 1'b1;
      else                 smp = ($urandom_range(0, 99) >= gap_pct);
      sample_valid_in      = smp;
      valid_meas_result_in = 1'($urandom_range(0, 1));
      meas_result_in       = 1'($urandom_range(0, 1));
      bus.coeff_req_valid  = 1'($urandom_range(0, 1));
      busy_readies("integrate");
      step();
      if (smp) got++;
      observe("integrate", 1'b0, (got == target), 1'b0, 1'b1, 1'b0);
      cyc++;
    end

    // FINISH cycle: a strobe here is ignored.
    bus.coeff_req_valid  = 1'b0;
    sample_valid_in      = 1'($urandom_range(0, 1));
    valid_meas_result_in = 1'($urandom_range(0, 1));
    busy_readies("finish");
    step();
    observe("finish_cycle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int w = 1; w <= TIMEOUT; w++) begin
      strobe               = (w == strobe_at);
      valid_meas_result_in = strobe;
      meas_result_in       = strobe ? res_bit : 1'($urandom_range(0, 1));
      sample_valid_in      = 1'($urandom_range(0, 1));
      busy_readies("wait");
      step();
      if (strobe) begin
        exp_out = res_bit;
        exp_to  = 1'b0;
        observe("result", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        break;
      end else if (w == TIMEOUT) begin
        exp_out = 1'b0;
        exp_to  = 1'b1;
        observe("timeout", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        observe("wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    valid_meas_result_in = 1'b0;
  endtask

  // Start a long window, then pull reset in the middle of integration.
  task automatic reset_mid_integrate();
    bus.meas_req_valid     = 1'b1;
    bus.meas_req_bin_count = BW'(20);
    step();
    observe("rst_accept", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.meas_req_valid = 1'b0;
    step();
    sample_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      observe("rst_integrate", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    rst     = 1'b0;
    exp_out = 1'b0;
    exp_to  = 1'b0;
    #1;
    observe("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    observe("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_data", wr_data, '0);
    rst = 1'b1;
    drive_idle(25);
  endtask

  initial begin
    rst                    = 1'b0;
    sample_valid_in        = 1'b0;
    valid_meas_result_in   = 1'b0;
    meas_result_in         = 1'b0;
    bus.meas_req_valid     = 1'b0;
    bus.meas_req_bin_count = '0;
    bus.coeff_req_valid    = 1'b0;
    bus.coeff_req_addr     = '0;
    bus.coeff_req_data     = '0;
    step();
    step();
    observe("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_wr_addr", wr_addr, '0);
    check("reset_wr_data", wr_data, '0);
    rst = 1'b1;
    drive_idle(5);

    // Two consecutive coefficient writes.
    coeff_burst(2, 1'b1, 1'b0);
    drive_idle(2);

    // bin_count=4, one gap in the samples, result bit 1 two cycles after finish.
    run_meas(4, 2, 1'b1, 1'b0, 1, 0);
    drive_idle(2);

    // Simultaneous requests: write first, then bin_count=0 closes after 1 sample.
    coeff_burst(1, 1'b0, 1'b1);
    run_meas(0, 3, 1'b0, 1'b0, -1, 30);
    drive_idle(1);

    // No strobe: forced result after the watchdog, then a strobe on its last cycle.
    run_meas(5, TIMEOUT + 3, 1'b1, 1'b0, -1, 30);
    run_meas(2, TIMEOUT, 1'b1, 1'b0, -1, 30);
    drive_idle(1);

    // Request held through a measurement is accepted as soon as it is idle.
    run_meas(3, 4, 1'b1, 1'b1, -1, 20);
    run_meas(6, 1, 1'b0, 1'b0, -1, 20);

    reset_mid_integrate();

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) coeff_burst($urandom_range(1, 4), 1'b0, 1'b0);
      drive_idle($urandom_range(0, 3));
      run_meas($urandom_range(0, 12), $urandom_range(1, TIMEOUT + 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1,
               $urandom_range(0, 60));
    end
    drive_idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/readout_rx_state_decision_controller_google.md
Name: readout_rx_state_decision_controller_google

Overview:
- Sequencer for one readout state decision unit. It writes classifier coefficients, drives the start_count/finish_count integration window and counts IQ samples. It collects the one-bit measurement result, with a watchdog timeout.
- Sits between the readout control/scheduler logic and the state decision unit's control inputs.
- One measurement is in flight at a time. Coefficient updates are accepted only while idle.

Parameters:
- STATE_DECISION_DATA_WIDTH, 8, width of coefficient write data.
- STATE_DECISION_ADDR_WIDTH, 1, width of coefficient write address.
- BIN_COUNT_WIDTH, 10, width of the requested integration length, in valid samples.
- RESULT_TIMEOUT, 8, maximum number of WAIT_RESULT cycles before a forced result.
- TIMEOUT_WIDTH, 4, width of the watchdog counter. Must satisfy RESULT_TIMEOUT < 2^TIMEOUT_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- meas_req_valid  in  1  measurement request.
- meas_req_ready  out  1  request accepted this cycle when high together with valid.
- meas_req_bin_count  in  BIN_COUNT_WIDTH  number of valid samples to integrate. 0 is treated as 1.
- coeff_req_valid  in  1  coefficient write request.
- coeff_req_ready  out  1  coefficient request accepted.
- coeff_req_addr  in  STATE_DECISION_ADDR_WIDTH  coefficient address.
- coeff_req_data  in  STATE_DECISION_DATA_WIDTH  coefficient value.
- sample_valid_in  in  1  copy of the decision unit's valid_in.
- start_count  out  1  one-cycle accumulator clear/start pulse.
- finish_count  out  1  one-cycle end-of-window pulse.
- state_decision_coeff_wr_en  out  1  coefficient write strobe.
- state_decision_coeff_wr_addr  out  STATE_DECISION_ADDR_WIDTH  coefficient write address.
- state_decision_coeff_wr_data  out  STATE_DECISION_DATA_WIDTH  coefficient write data.
- valid_meas_result_in  in  1  result strobe from the decision unit.
- meas_result_in  in  1  result bit from the decision unit.
- result_valid  out  1  one-cycle result strobe to the requester.
- result_out  out  1  measured state.
- result_timeout  out  1  qualifies result_valid; high means the result was forced.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: while rst is low, FSM goes to IDLE and every output register and counter is 0. This applies mid-measurement too; no pulse is emitted on reset release.
- All outputs are registered, except meas_req_ready and coeff_req_ready, which are decoded from state and inputs.
- FSM states: IDLE, START, INTEGRATE, FINISH, WAIT_RESULT.
- IDLE, coefficient path:
  - coeff_req_ready = coeff_req_valid.
  - An accept at cycle T gives wr_en=1 at T+1, with addr/data captured at T.
  - Back-to-back writes are allowed every cycle.
  - wr_en is 0 whenever no write was accepted in the previous cycle.
- IDLE, measurement path:
  - meas_req_ready = meas_req_valid & ~coeff_req_valid. Coefficients win simultaneous requests.
  - An accept at T latches max(bin_count,1), clears the sample counter and enters START.
- START (one cycle): start_count=1 at T+1. sample_valid_in is not counted in this cycle. Next state is INTEGRATE.
- INTEGRATE:
  - The counter increments on each sample_valid_in.
  - When the counter equals target-1 and sample_valid_in=1 at cycle S, the FSM enters FINISH, so finish_count=1 at S+1.
  - Gaps in sample_valid_in extend the window without limit.
- FINISH (one cycle): clears the watchdog and enters WAIT_RESULT.
- WAIT_RESULT:
  - The watchdog increments every cycle.
  - valid_meas_result_in=1 at cycle R gives result_valid=1, result_out=meas_result_in and result_timeout=0 at R+1, then IDLE.
  - If RESULT_TIMEOUT cycles elapse without a strobe, the block emits result_valid=1, result_out=0 and result_timeout=1, then goes to IDLE.
  - If the strobe arrives in the same cycle as the timeout, the strobe wins.
- valid_meas_result_in is ignored in every state except WAIT_RESULT.
- Both request readies are 0 outside IDLE. A request that is held stays pending and is not lost.
- result_valid, start_count, finish_count and wr_en are single-cycle pulses. result_out and result_timeout hold their values until the next result_valid.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0. Assert rst low mid-INTEGRATE -> next cycle is IDLE, no finish_count, no result.
- coeff writes (addr0,0x12) then (addr1,0xF3) on consecutive cycles -> wr_en high 2 cycles with matching addr/data, each one cycle after its accept.
- meas_req (bin_count=4) accepted at T -> start_count at T+1. Four samples with one gap -> finish_count one cycle after the 4th sample. valid_meas_result_in=1 with meas_result_in=1 two cycles later -> result_valid, result_out=1, result_timeout=0.
- coeff_req_valid and meas_req_valid asserted together -> write accepted first, measurement accepted the next cycle. bin_count=0 -> window closes after exactly 1 sample.
- No result strobe after finish_count, RESULT_TIMEOUT=8 -> result_valid with result_out=0, result_timeout=1 after 8 WAIT_RESULT cycles, then busy=0.
- Stray valid_meas_result_in during IDLE and INTEGRATE -> no result_valid. meas_req held during busy -> ready=0 until IDLE, then accepted.
